// File: rtl/note_sequencer.sv
// note_sequencer
//   Plays a fixed 8-entry melody into one synthesizer channel. A push-button
//   toggles playback; each note lasts a whole number of tempo steps, and the
//   final GAP_TICKS cycles of every note are silenced so that repeated notes
//   articulate.
//
// Parameters
//   TICK_DIV  : clock cycles per tempo step (>= 2)
//   GAP_TICKS : silent cycles at the end of each note (0 < GAP_TICKS < TICK_DIV)
//   LOOP      : 1 wraps entry 7 -> entry 0, 0 stops after entry 7
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   play_btn in   raw asynchronous button, each rising edge toggles play/stop
//   pitch    out  12-bit divider code for channel.pitch (registered)
//   waveform out  2-bit waveform select for channel.waveform (registered)
//   ena      out  channel enable (registered)
//   step     out  index of the current melody entry (registered)
//   playing  out  high while a note (sounding or gap) is in progress (registered)
module note_sequencer #(
    parameter int unsigned TICK_DIV  = 1_500_000,
    parameter int unsigned GAP_TICKS = 120_000,
    parameter bit          LOOP      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_btn,
    output logic [11:0] pitch,
    output logic [1:0]  waveform,
    output logic        ena,
    output logic [2:0]  step,
    output logic        playing
);

    localparam int unsigned NW = $clog2(4 * TICK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // ROM word layout: {pitch[11:0], duration-1[1:0], waveform[1:0]}
    function automatic logic [15:0] melody_rom(input logic [2:0] idx);
        melody_rom = '0;
        case (idx)
            3'd0: melody_rom = {12'd178, 2'd1, 2'b10};
            3'd1: melody_rom = {12'd133, 2'd0, 2'b10};
            3'd2: melody_rom = {12'd0,   2'd0, 2'b00};
            3'd3: melody_rom = {12'd89,  2'd0, 2'b01};
            3'd4: melody_rom = {12'd44,  2'd3, 2'b10};
            3'd5: melody_rom = {12'd59,  2'd1, 2'b00};
            3'd6: melody_rom = {12'd0,   2'd1, 2'b00};
            3'd7: melody_rom = {12'd178, 2'd0, 2'b11};
            default: melody_rom = '0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Button synchronizer and rising-edge detector
    // ------------------------------------------------------------------
    logic sync1, sync2, prev;
    logic fill1, fill2;
    logic toggle;

    // fill1/fill2 track whether sync2 holds a real button sample yet. Until
    // it does, prev is pinned high, so a button held through reset has to be
    // seen low before it can produce a toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b1;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
        end else begin
            sync1 <= play_btn;
            sync2 <= sync1;
            fill1 <= 1'b1;
            fill2 <= fill1;
            prev  <= fill2 ? sync2 : 1'b1;
        end
    end

    assign toggle = sync2 & ~prev;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic [NW-1:0] ncnt, ncnt_n;
    logic [2:0]    step_n;
    logic [11:0]   pitch_n;
    logic [1:0]    waveform_n;
    logic          ena_n;
    logic          playing_n;

    logic [15:0]   rom_cur, rom_next, rom_first;
    logic [31:0]   note_len, gap_start, note_end, ncnt_ext;
    logic          go_idle;

    assign rom_cur   = melody_rom(step);
    assign rom_next  = melody_rom(step + 3'd1);
    assign rom_first = melody_rom(3'd0);

    assign note_len  = (32'(rom_cur[3:2]) + 32'd1) * TICK_DIV;
    assign gap_start = note_len - GAP_TICKS - 32'd1;
    assign note_end  = note_len - 32'd1;
    assign ncnt_ext  = 32'(ncnt);

    always_comb begin
        state_n    = state;
        ncnt_n     = ncnt;
        step_n     = step;
        pitch_n    = pitch;
        waveform_n = waveform;
        ena_n      = ena;
        go_idle    = 1'b0;

        case (state)
            IDLE: begin
                if (toggle) begin
                    state_n    = PLAY;
                    ncnt_n     = '0;
                    step_n     = '0;
                    pitch_n    = rom_first[15:4];
                    waveform_n = rom_first[1:0];
                    ena_n      = (rom_first[15:4] != 12'd0);
                end
            end
            PLAY: begin
                if (toggle) begin
                    go_idle = 1'b1;
                end else begin
                    ncnt_n = ncnt + NW'(1);
                    if (ncnt_ext == gap_start) begin
                        state_n = GAP;
                        ena_n   = 1'b0;
                    end
                end
            end
            GAP: begin
                // A toggle wins over a note end landing on the same cycle.
                if (toggle) begin
                    go_idle = 1'b1;
                end else if (ncnt_ext == note_end) begin
                    if (step == 3'd7 && LOOP == 1'b0) begin
                        go_idle = 1'b1;
                    end else begin
                        state_n    = PLAY;
                        ncnt_n     = '0;
                        step_n     = step + 3'd1;
                        pitch_n    = rom_next[15:4];
                        waveform_n = rom_next[1:0];
                        ena_n      = (rom_next[15:4] != 12'd0);
                    end
                end else begin
                    ncnt_n = ncnt + NW'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_n    = IDLE;
            ncnt_n     = '0;
            step_n     = '0;
            pitch_n    = '0;
            waveform_n = '0;
            ena_n      = 1'b0;
        end

        playing_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ncnt     <= '0;
            step     <= '0;
            pitch    <= '0;
            waveform <= '0;
            ena      <= 1'b0;
            playing  <= 1'b0;
        end else begin
            state    <= state_n;
            ncnt     <= ncnt_n;
            step     <= step_n;
            pitch    <= pitch_n;
            waveform <= waveform_n;
            ena      <= ena_n;
            playing  <= playing_n;
        end
    end

endmodule
